// File: rtl/fifo_pkg.sv
// Shared defaults and types for the single-clock FIFO.
package fifo_pkg;

  localparam int unsigned DEF_WIDTH       = 8;
  localparam int unsigned DEF_DEPTH       = 16;
  localparam int unsigned DEF_ADDR_WIDTH  = 4;
  localparam int unsigned DEF_COUNT_WIDTH = DEF_ADDR_WIDTH + 1;

  // Encoded as {write_accepted, read_accepted}.
  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_BOTH  = 2'b11
  } op_e;

  function automatic int unsigned count_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port RAM: one write port, one registered read port.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is deliberately not reset; only the read register is.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fifo.sv
// Single-clock FIFO: pointers, occupancy count, flags and accept logic around fifo_mem.
module fifo
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             write_enable,
  input  logic             read_enable,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

  localparam int unsigned CW = count_width(ADDR_WIDTH);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  if (DEPTH != (1 << ADDR_WIDTH)) begin : g_depth_check
    $fatal(1, "fifo: DEPTH must equal 2**ADDR_WIDTH");
  end

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CW-1:0]         count;
  logic                  wr_acc;
  logic                  rd_acc;
  op_e                   op;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

  // A write while full is still accepted when a read frees the slot the same cycle.
  always_comb begin
    rd_acc = read_enable && !empty;
    wr_acc = write_enable && (!full || rd_acc);
    op     = op_e'({wr_acc, rd_acc});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case (op)
        OP_WRITE: count <= count + 1'b1;
        OP_READ:  count <= count - 1'b1;
        default:  count <= count;
      endcase
    end
  end

  fifo_mem #(
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (data_in),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr),
    .rd_data (data_out)
  );

`ifndef SYNTHESIS
  a_count_range: assert property (@(posedge clk) disable iff (!rst_n) count <= FULL_COUNT);
  a_flags_excl:  assert property (@(posedge clk) disable iff (!rst_n) !(full && empty));
`endif

endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo: vector table plus queue-based scoreboard.
module tb_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_in;
  logic       write_enable;
  logic       read_enable;
  logic [7:0] data_out;
  logic       full;
  logic       empty;

  int checks = 0;
  int errors = 0;

  logic [7:0] sb[$];
  int         mcount;
  logic [7:0] exp_dout;

  typedef struct {
    logic       we;
    logic       re;
    logic [7:0] din;
    logic [7:0] dout;
    logic       full;
    logic       empty;
  } vec_t;

  vec_t tbl[9];

  fifo #(
    .WIDTH      (8),
    .DEPTH      (16),
    .ADDR_WIDTH (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .data_out     (data_out),
    .full         (full),
    .empty        (empty)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock: drive, update the reference model, compare after the edge.
  task automatic step(input logic we, input logic re, input logic [7:0] din);
    bit rd_ok;
    bit wr_ok;
    write_enable = we;
    read_enable  = re;
    data_in      = din;
    rd_ok = re && (mcount != 0);
    wr_ok = we && ((mcount != 16) || rd_ok);
    if (rd_ok) exp_dout = sb.pop_front();
    if (wr_ok) sb.push_back(din);
    mcount = mcount + int'(wr_ok) - int'(rd_ok);
    @(posedge clk);
    #1;
    chk("sb_data_out", data_out, exp_dout);
    chk("sb_full", {7'd0, full}, {7'd0, mcount == 16});
    chk("sb_empty", {7'd0, empty}, {7'd0, mcount == 0});
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 8'hA1, 8'h00, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 8'hB2, 8'h00, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 8'h00, 8'hA1, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 8'hC3, 8'hA1, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 8'h00, 8'hB2, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 8'h00, 8'hC3, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 8'h00, 8'hC3, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 1'b1, 8'h77, 8'hC3, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 8'h00, 8'h77, 1'b0, 1'b1};

    mcount       = 0;
    exp_dout     = 8'h00;
    rst_n        = 1'b0;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    data_in      = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("reset_empty", {7'd0, empty}, 8'd1);
    chk("reset_full", {7'd0, full}, 8'd0);
    chk("reset_data_out", data_out, 8'h00);

    // Basic ordering, underflow and simultaneous read/write while empty.
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].we, tbl[i].re, tbl[i].din);
      chk($sformatf("vec%0d_data_out", i), data_out, tbl[i].dout);
      chk($sformatf("vec%0d_full", i), {7'd0, full}, {7'd0, tbl[i].full});
      chk($sformatf("vec%0d_empty", i), {7'd0, empty}, {7'd0, tbl[i].empty});
    end

    // Fill, overflow attempt, drain; twice to exercise pointer wrap.
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(i));
      chk("fill_full", {7'd0, full}, 8'd1);
      step(1'b1, 1'b0, 8'hFF);
      chk("overflow_full", {7'd0, full}, 8'd1);
      for (int i = 0; i < 16; i++) begin
        step(1'b0, 1'b1, 8'h00);
        chk("drain_order", data_out, 8'(i));
      end
      chk("drain_empty", {7'd0, empty}, 8'd1);
      step(1'b0, 1'b1, 8'h00);
      chk("underflow_hold", data_out, 8'h0F);
    end

    // Simultaneous read and write while full.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'h20 + i));
    step(1'b1, 1'b1, 8'h5A);
    chk("both_full_data_out", data_out, 8'h20);
    chk("both_full_full", {7'd0, full}, 8'd1);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00);
    chk("both_full_last", data_out, 8'h5A);
    chk("both_full_empty", {7'd0, empty}, 8'd1);

    // Asynchronous reset between edges discards contents at once.
    step(1'b1, 1'b0, 8'h11);
    step(1'b1, 1'b0, 8'h22);
    step(1'b1, 1'b0, 8'h33);
    step(1'b0, 1'b1, 8'h00);
    chk("pre_reset_data_out", data_out, 8'h11);
    write_enable = 1'b0;
    read_enable  = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_empty", {7'd0, empty}, 8'd1);
    chk("async_reset_data_out", data_out, 8'h00);
    chk("async_reset_full", {7'd0, full}, 8'd0);
    #1;
    rst_n = 1'b1;
    sb.delete();
    mcount   = 0;
    exp_dout = 8'h00;
    step(1'b0, 1'b1, 8'h00);
    chk("post_reset_read", data_out, 8'h00);
    step(1'b1, 1'b0, 8'h44);
    step(1'b0, 1'b1, 8'h00);
    chk("post_reset_write_read", data_out, 8'h44);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
